ssd_display_driver: RTL

SSD_DISPLAY_DRIVER -- requirements
Module: ssd_display_driver

---
 rtl/ssd_display_driver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ssd_display_driver.sv
// Four-digit seven-segment driver: converts a 13-bit binary value to BCD by
// double dabble and time-multiplexes the digits onto shared active-low cathodes.
module ssd_display_driver #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] num,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [15:0] bcd,
  output logic        busy
);

  // state | meaning
  // IDLE  | compare num against the last captured value, start on change
  // SHIFT | 13 double-dabble steps, shift_cnt counts down 12..0
  // LOAD  | publish the finished working BCD to the display register
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                  state_q, state_d;
  logic [12:0]             cap_q, cap_d;
  logic [12:0]             bin_q, bin_d;
  logic [15:0]             work_q, work_d;
  logic [15:0]             bcd_q, bcd_d;
  logic [15:0]             adj;
  logic [3:0]              shift_cnt_q, shift_cnt_d;
  logic                    busy_q, busy_d;
  logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
  logic [1:0]              sel;
  logic [3:0]              digit;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    bin_d       = bin_q;
    work_d      = work_q;
    bcd_d       = bcd_q;
    shift_cnt_d = shift_cnt_q;
    adj         = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (num != cap_q) begin
          cap_d       = num;
          bin_d       = num;
          work_d      = 16'd0;
          shift_cnt_d = 4'd12;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        work_d      = {adj[14:0], bin_q[12]};
        bin_d       = {bin_q[11:0], 1'b0};
        shift_cnt_d = shift_cnt_q - 4'd1;
        if (shift_cnt_q == 4'd0) state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = work_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    refresh_d = refresh_q + REFRESH_BITS'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cap_q       <= 13'd0;
      bin_q       <= 13'd0;
      work_q      <= 16'd0;
      bcd_q       <= 16'd0;
      shift_cnt_q <= 4'd0;
      busy_q      <= 1'b0;
      refresh_q   <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      bcd_q       <= bcd_d;
      shift_cnt_q <= shift_cnt_d;
      busy_q      <= busy_d;
      refresh_q   <= refresh_d;
    end
  end

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    anode = 4'b1110;
    digit = bcd_q[3:0];
    case (sel)
      2'd0: begin anode = 4'b1110; digit = bcd_q[3:0];   end
      2'd1: begin anode = 4'b1101; digit = bcd_q[7:4];   end
      2'd2: begin anode = 4'b1011; digit = bcd_q[11:8];  end
      default: begin anode = 4'b0111; digit = bcd_q[15:12]; end
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule
